// File: rtl/cmt_result_packer.sv
// Output stage of the CMT matrix-multiply AFU: packs 64-bit result words into
// 512-bit cache lines, pads with zero lines up to the requested count, then signals done.
module cmt_result_packer #(
  parameter int IN_WIDTH    = 64,
  parameter int CL_WIDTH    = 512,
  parameter int COUNT_WIDTH = 43
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] out_cl_size,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   pipe_done,
  output logic [CL_WIDTH-1:0]    cl_data,
  output logic                   cl_valid,
  input  logic                   cl_ready,
  output logic [COUNT_WIDTH-1:0] cl_count,
  output logic                   done,
  output logic                   overflow
);

  localparam int WORDS = CL_WIDTH / IN_WIDTH;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, PACK, FILL, DONE_WAIT, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] size;
  logic [COUNT_WIDTH-1:0] queued;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [IDX_W-1:0]       idx;
  logic [CL_WIDTH-1:0]    asm_q;
  logic [CL_WIDTH-1:0]    line_next;
  logic                   pd_seen;
  logic                   xfer, out_free, room, pipe_end, accept;
  logic                   load_full, load_flush, load_zero, load;

  // Keep words 0..n-1 of a partial line, zero the rest.
  function automatic logic [CL_WIDTH-1:0] keep_words(input logic [CL_WIDTH-1:0] line,
                                                    input logic [IDX_W-1:0]    n);
    logic [CL_WIDTH-1:0] res;
    res = line;
    for (int k = 0; k < WORDS; k++) begin
      if (k >= int'(n)) res[k*IN_WIDTH +: IN_WIDTH] = '0;
    end
    return res;
  endfunction

  assign xfer       = cl_valid && cl_ready;
  assign out_free   = !cl_valid || cl_ready;
  assign room       = queued < size;
  assign pipe_end   = pipe_done || pd_seen;
  assign count_next = xfer ? cl_count + COUNT_WIDTH'(1) : cl_count;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      PACK:            in_ready = room && (idx != LAST_IDX || out_free);
      DONE_WAIT, DONE: in_ready = 1'b1;
      default:         in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign load_full  = (state == PACK) && accept && (idx == LAST_IDX);
  assign load_flush = (state == PACK) && pipe_end && !in_valid && (idx != '0) && out_free && room;
  assign load_zero  = (state == FILL) && out_free && room;
  assign load       = load_full || load_flush || load_zero;

  always_comb begin
    line_next = '0;
    if (load_full)       line_next = {in_data, asm_q[CL_WIDTH-IN_WIDTH-1:0]};
    else if (load_flush) line_next = keep_words(asm_q, idx);
  end

  // Assembly buffer is pure data; idx governs which words are meaningful.
  always_ff @(posedge clk) begin
    if (state == PACK && accept && idx != LAST_IDX)
      asm_q[int'(idx)*IN_WIDTH +: IN_WIDTH] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      size     <= '0;
      queued   <= '0;
      idx      <= '0;
      pd_seen  <= 1'b0;
      cl_data  <= '0;
      cl_valid <= 1'b0;
      cl_count <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (go) begin
      state    <= PACK;
      size     <= out_cl_size;
      queued   <= '0;
      idx      <= '0;
      pd_seen  <= 1'b0;
      cl_valid <= 1'b0;
      cl_count <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cl_count <= count_next;
      if (load) begin
        cl_data  <= line_next;
        cl_valid <= 1'b1;
        queued   <= queued + COUNT_WIDTH'(1);
      end else if (xfer) begin
        cl_valid <= 1'b0;
      end

      if (load_full || load_flush)            idx <= '0;
      else if (state == PACK && accept)       idx <= idx + IDX_W'(1);

      if (state == PACK && pipe_done)         pd_seen <= 1'b1;
      if (accept && (state == DONE_WAIT || state == DONE)) overflow <= 1'b1;

      // Enter DONE on the edge of the final transfer so done follows it by one cycle.
      case (state)
        PACK: begin
          if (!room) begin
            if (count_next == size) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DONE_WAIT;
            end
          end else if (pipe_end && !in_valid && idx == '0) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (!room) begin
            if (count_next == size) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DONE_WAIT;
            end
          end
        end
        DONE_WAIT: begin
          if (count_next == size) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmt_result_packer.sv
// Directed bench for cmt_result_packer: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_cmt_result_packer;

  localparam int IN_WIDTH = 64;
  localparam int CL_WIDTH = 512;
  localparam int COUNT_WIDTH = 43;

  logic                   clk = 1'b0;
  logic                   rst, go, in_valid, in_ready, pipe_done;
  logic [COUNT_WIDTH-1:0] out_cl_size, cl_count;
  logic [IN_WIDTH-1:0]    in_data;
  logic [CL_WIDTH-1:0]    cl_data;
  logic                   cl_valid, cl_ready, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CL_WIDTH-1:0] lines[$];

  cmt_result_packer #(.IN_WIDTH(IN_WIDTH), .CL_WIDTH(CL_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .go(go), .out_cl_size(out_cl_size),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .pipe_done(pipe_done),
    .cl_data(cl_data), .cl_valid(cl_valid), .cl_ready(cl_ready),
    .cl_count(cl_count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cl_valid && cl_ready) lines.push_back(cl_data);
  end

  task automatic check(input string tag, input logic [CL_WIDTH-1:0] obs, input logic [CL_WIDTH-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL_WIDTH-1:0] seq_line(input int start, input int n);
    logic [CL_WIDTH-1:0] l;
    l = '0;
    for (int k = 0; k < n; k++) l[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(start + k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input int sz);
    lines.delete();
    go = 1'b1;
    out_cl_size = COUNT_WIDTH'(sz);
    tick();
    go = 1'b0;
  endtask

  task automatic send_word(input logic [IN_WIDTH-1:0] w, input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check({tag, "_accept_timeout"}, in_ready, 1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 100 && !done; c++) tick();
    check(tag, done, 1);
  endtask

  initial begin
    int nxt;
    logic acc;
    rst = 1'b1; go = 1'b0; out_cl_size = '0; in_data = '0; in_valid = 1'b0;
    pipe_done = 1'b0; cl_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_cl_valid", cl_valid, 0);
    check("rst_cl_count", cl_count, 0);
    check("rst_cl_data", cl_data, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);

    // Two full lines, back-to-back words, sink always ready
    do_go(2);
    for (int i = 1; i <= 8; i++) send_word(IN_WIDTH'(i), "t1");
    check("t1_lat_line0", cl_valid, 1);
    for (int i = 9; i <= 16; i++) send_word(IN_WIDTH'(i), "t1");
    check("t1_lat_line1", cl_valid, 1);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_count", cl_count, 2);
    check("t1_nlines", lines.size(), 2);
    if (lines.size() == 2) begin
      check("t1_line0", lines[0], seq_line(1, 8));
      check("t1_line1", lines[1], seq_line(9, 8));
    end

    // Sink stalled: upstream must be back-pressured after 15 words
    do_go(2);
    cl_ready = 1'b0;
    nxt = 1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (nxt <= 16);
      in_data  = IN_WIDTH'(nxt);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) nxt++;
    end
    check("t2_accepted", nxt - 1, 15);
    check("t2_stall_ready", in_ready, 0);
    check("t2_stall_valid", cl_valid, 1);
    cl_ready = 1'b1;
    for (int c = 0; c < 50 && nxt <= 16; c++) begin
      in_valid = 1'b1;
      in_data  = IN_WIDTH'(nxt);
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    wait_done("t2_done");
    check("t2_nlines", lines.size(), 2);
    if (lines.size() == 2) begin
      check("t2_line0", lines[0], seq_line(1, 8));
      check("t2_line1", lines[1], seq_line(9, 8));
    end

    // Partial line flushed with zero padding
    do_go(1);
    send_word(64'hA, "t3");
    send_word(64'hB, "t3");
    send_word(64'hC, "t3");
    pipe_done = 1'b1;
    wait_done("t3_done");
    pipe_done = 1'b0;
    check("t3_nlines", lines.size(), 1);
    if (lines.size() == 1) check("t3_line", lines[0], {320'h0, 64'hC, 64'hB, 64'hA});
    check("t3_overflow", overflow, 0);

    // One data line then two zero filler lines
    do_go(3);
    for (int i = 1; i <= 8; i++) send_word(IN_WIDTH'(i), "t4");
    pipe_done = 1'b1;
    wait_done("t4_done");
    pipe_done = 1'b0;
    check("t4_count", cl_count, 3);
    check("t4_nlines", lines.size(), 3);
    if (lines.size() == 3) begin
      check("t4_line0", lines[0], seq_line(1, 8));
      check("t4_line1", lines[1], '0);
      check("t4_line2", lines[2], '0);
    end

    // Ninth word beyond the requested size is swallowed and flagged
    do_go(1);
    for (int i = 1; i <= 9; i++) send_word(IN_WIDTH'(i), "t5");
    tick();
    check("t5_overflow", overflow, 1);
    check("t5_done", done, 1);
    check("t5_count", cl_count, 1);
    check("t5_nlines", lines.size(), 1);
    if (lines.size() == 1) check("t5_line", lines[0], seq_line(1, 8));

    // Restart mid-line discards the partial assembly
    do_go(1);
    for (int i = 101; i <= 105; i++) send_word(IN_WIDTH'(i), "t6a");
    check("t6_overflow_before", overflow, 0);
    do_go(1);
    for (int i = 33; i <= 40; i++) send_word(IN_WIDTH'(i), "t6b");
    wait_done("t6_done");
    check("t6_overflow", overflow, 0);
    check("t6_nlines", lines.size(), 1);
    if (lines.size() == 1) check("t6_line", lines[0], seq_line(33, 8));

    // Zero-size request completes without emitting a line
    do_go(0);
    check("t7_done_g1", done, 0);
    check("t7_valid_g1", cl_valid, 0);
    tick();
    check("t7_done_g2", done, 1);
    check("t7_valid_g2", cl_valid, 0);
    check("t7_count", cl_count, 0);
    check("t7_nlines", lines.size(), 0);

    // Reset wins over go
    rst = 1'b1; go = 1'b1; out_cl_size = 5;
    tick();
    rst = 1'b0; go = 1'b0;
    in_valid = 1'b1; in_data = 64'h55;
    tick();
    check("t8_in_ready", in_ready, 0);
    check("t8_done", done, 0);
    check("t8_overflow", overflow, 0);
    tick();
    check("t8_in_ready2", in_ready, 0);
    check("t8_cl_valid", cl_valid, 0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
